write_back_stage: RTL and testbench

WRITE_BACK_STAGE -- requirements
Module: write_back_stage

---
 rtl/write_back_stage.sv | 108 ++++++++++
 tb/tb_write_back_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/write_back_stage.sv
// Write-back stage: registers the retiring result onto the register-file write
// port and tracks per-register pending-write counts for issue hazard stalls.
module write_back_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [3:0]  in_opcode,
    input  logic [3:0]  in_dest,
    input  logic [15:0] alu_result,
    input  logic [15:0] mem_data,
    input  logic        issue_valid,
    input  logic [3:0]  issue_opcode,
    input  logic [3:0]  issue_dest,
    output logic        WriteEnable,
    output logic [3:0]  WriteAddress,
    output logic [15:0] WriteData,
    output logic [15:0] busy,
    output logic        issue_stall,
    output logic [15:0] retire_count
);

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned CNT_W    = 2;

    localparam logic [REG_W-1:0] OP_LOAD  = 4'b1011;
    localparam logic [REG_W-1:0] OP_STORE = 4'b1100;
    localparam logic [REG_W-1:0] OP_BRAN  = 4'b1101;
    localparam logic [REG_W-1:0] OP_NOP   = 4'b1111;
    localparam logic [CNT_W-1:0] CNT_MAX  = 2'd3;

    function automatic logic is_writer(input logic [REG_W-1:0] op, input logic [REG_W-1:0] dst);
        return !(op == OP_STORE || op == OP_BRAN || op == OP_NOP) && (dst != '0);
    endfunction

    logic                               we_q, we_d;
    logic [REG_W-1:0]                   waddr_q, waddr_d;
    logic [DATA_W-1:0]                  wdata_q, wdata_d;
    logic [DATA_W-1:0]                  rcount_q, rcount_d;
    logic [NUM_REGS-1:0][CNT_W-1:0]     pending_q, pending_d;
    logic [NUM_REGS-1:0]                busy_q, busy_d;

    logic                               write_c;
    logic                               issue_inc_c;
    logic [NUM_REGS-1:0]                inc_vec_c;
    logic [NUM_REGS-1:0]                dec_vec_c;

    // Hazard check and increment/decrement event decode
    always_comb begin
        write_c     = in_valid && is_writer(in_opcode, in_dest);
        issue_stall = issue_valid && is_writer(issue_opcode, issue_dest)
                      && (pending_q[issue_dest] == CNT_MAX);
        issue_inc_c = issue_valid && is_writer(issue_opcode, issue_dest) && !issue_stall;
        inc_vec_c   = issue_inc_c ? (NUM_REGS'(1) << issue_dest) : '0;
        dec_vec_c   = write_c ? (NUM_REGS'(1) << in_dest) : '0;
    end

    // Next-state for write port, retire counter and pending counters
    always_comb begin
        we_d      = write_c;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        rcount_d  = rcount_q + DATA_W'(in_valid);
        pending_d = pending_q;
        busy_d    = '0;
        if (write_c) begin
            waddr_d = in_dest;
            wdata_d = (in_opcode == OP_LOAD) ? mem_data : alu_result;
        end
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (inc_vec_c[r] && !dec_vec_c[r]) begin
                pending_d[r] = pending_q[r] + CNT_W'(1);
            end else if (dec_vec_c[r] && !inc_vec_c[r] && (pending_q[r] != '0)) begin
                pending_d[r] = pending_q[r] - CNT_W'(1);
            end
        end
        pending_d[0] = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            busy_d[r] = (pending_d[r] != '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            rcount_q  <= '0;
            pending_q <= '0;
            busy_q    <= '0;
        end else begin
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            rcount_q  <= rcount_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
        end
    end

    assign WriteEnable  = we_q;
    assign WriteAddress = waddr_q;
    assign WriteData    = wdata_q;
    assign retire_count = rcount_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_write_back_stage.sv
// Scoreboard bench for write_back_stage: a behavioural model predicts each
// cycle's write port, retire count and busy map, queued and compared post-edge.
`timescale 1ns/1ps
module tb_write_back_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  in_opcode;
    logic [3:0]  in_dest;
    logic [15:0] alu_result;
    logic [15:0] mem_data;
    logic        issue_valid;
    logic [3:0]  issue_opcode;
    logic [3:0]  issue_dest;
    logic        WriteEnable;
    logic [3:0]  WriteAddress;
    logic [15:0] WriteData;
    logic [15:0] busy;
    logic        issue_stall;
    logic [15:0] retire_count;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [15:0] cnt;
        logic [15:0] busy;
    } exp_t;

    exp_t        sb_q[$];
    int          err_cnt = 0;
    int          chk_cnt = 0;

    int          m_pend[16];
    logic        m_we;
    logic [3:0]  m_addr;
    logic [15:0] m_data;
    logic [15:0] m_cnt;

    write_back_stage dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_opcode    (in_opcode),
        .in_dest      (in_dest),
        .alu_result   (alu_result),
        .mem_data     (mem_data),
        .issue_valid  (issue_valid),
        .issue_opcode (issue_opcode),
        .issue_dest   (issue_dest),
        .WriteEnable  (WriteEnable),
        .WriteAddress (WriteAddress),
        .WriteData    (WriteData),
        .busy         (busy),
        .issue_stall  (issue_stall),
        .retire_count (retire_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, want $finish)");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic wr_op(input logic [3:0] op, input logic [3:0] dst);
        if (dst == 4'd0) return 1'b0;
        if (op == 4'b1100 || op == 4'b1101 || op == 4'b1111) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [15:0] model_busy();
        logic [15:0] b;
        for (int r = 0; r < 16; r++) b[r] = (m_pend[r] != 0);
        return b;
    endfunction

    task automatic compare_head(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq({name, ".sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check_eq({name, ".we"},    32'(WriteEnable),  32'(e.we));
        check_eq({name, ".waddr"}, 32'(WriteAddress), 32'(e.addr));
        check_eq({name, ".wdata"}, 32'(WriteData),    32'(e.data));
        check_eq({name, ".rcount"},32'(retire_count), 32'(e.cnt));
        check_eq({name, ".busy"},  32'(busy),         32'(e.busy));
    endtask

    // One clock of stimulus: entered and left at posedge+1
    task automatic step(input string name,
                        input logic iv, input logic [3:0] iop, input logic [3:0] idst,
                        input logic [15:0] alu, input logic [15:0] mem,
                        input logic isv, input logic [3:0] isop, input logic [3:0] isd);
        logic exp_stall;
        logic wr;
        exp_t e;
        in_valid = iv; in_opcode = iop; in_dest = idst;
        alu_result = alu; mem_data = mem;
        issue_valid = isv; issue_opcode = isop; issue_dest = isd;
        exp_stall = isv && wr_op(isop, isd) && (m_pend[isd] == 3);
        #1;
        check_eq({name, ".stall"}, 32'(issue_stall), 32'(exp_stall));
        wr = iv && wr_op(iop, idst);
        m_we = wr;
        if (wr) begin
            m_addr = idst;
            m_data = (iop == 4'b1011) ? mem : alu;
        end
        if (iv) m_cnt = m_cnt + 16'd1;
        if (isv && wr_op(isop, isd) && !exp_stall) m_pend[isd] = m_pend[isd] + 1;
        if (wr && m_pend[idst] != 0) m_pend[idst] = m_pend[idst] - 1;
        e.we = m_we; e.addr = m_addr; e.data = m_data; e.cnt = m_cnt; e.busy = model_busy();
        sb_q.push_back(e);
        @(posedge clock); #1;
        compare_head(name);
    endtask

    // Reset with live in_valid/issue traffic that must be ignored
    task automatic do_reset(input string name);
        exp_t e;
        reset = 1'b1;
        in_valid = 1'b1; in_opcode = 4'b0001; in_dest = 4'd6;
        alu_result = 16'hAAAA; mem_data = 16'h5555;
        issue_valid = 1'b1; issue_opcode = 4'b0001; issue_dest = 4'd6;
        for (int r = 0; r < 16; r++) m_pend[r] = 0;
        m_we = 1'b0; m_addr = '0; m_data = '0; m_cnt = '0;
        e.we = 1'b0; e.addr = '0; e.data = '0; e.cnt = '0; e.busy = '0;
        sb_q.push_back(e);
        @(posedge clock); #1;
        reset = 1'b0;
        issue_valid = 1'b1; issue_opcode = 4'b0001; issue_dest = 4'd6;
        in_valid = 1'b0;
        compare_head(name);
        #1;
        check_eq({name, ".stall_after"}, 32'(issue_stall), 32'd0);
        issue_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_opcode = '0; in_dest = '0;
        alu_result = '0; mem_data = '0;
        issue_valid = 1'b0; issue_opcode = '0; issue_dest = '0;
        @(posedge clock); #1;
        do_reset("rst0");

        // basic ALU write, load, store
        step("alu5",  1, 4'b0001, 4'd5, 16'h1234, 16'h0000, 0, 4'h0, 4'd0);
        check_eq("alu5.lit_data", 32'(WriteData), 32'h1234);
        check_eq("alu5.lit_cnt",  32'(retire_count), 32'd1);
        step("load3", 1, 4'b1011, 4'd3, 16'h0000, 16'hBEEF, 0, 4'h0, 4'd0);
        check_eq("load3.lit_data", 32'(WriteData), 32'hBEEF);
        step("store", 1, 4'b1100, 4'd4, 16'h7777, 16'h8888, 0, 4'h0, 4'd0);
        check_eq("store.lit_cnt", 32'(retire_count), 32'd3);

        // fill r7 to 3 pending, then stall, then drain one
        step("iss7a", 0, 4'h0, 4'd0, 16'h0, 16'h0, 1, 4'b0001, 4'd7);
        step("iss7b", 0, 4'h0, 4'd0, 16'h0, 16'h0, 1, 4'b0010, 4'd7);
        step("iss7c", 0, 4'h0, 4'd0, 16'h0, 16'h0, 1, 4'b1011, 4'd7);
        check_eq("iss7.busy7", 32'(busy[7]), 32'd1);
        step("iss7d", 0, 4'h0, 4'd0, 16'h0, 16'h0, 1, 4'b0001, 4'd7);
        step("ret7",  1, 4'b0001, 4'd7, 16'h0707, 16'h0, 0, 4'h0, 4'd0);
        step("iss7e", 0, 4'h0, 4'd0, 16'h0, 16'h0, 1, 4'b0001, 4'd7);

        // same-edge issue+retire on r4 leaves pending at 1
        step("iss4",  0, 4'h0, 4'd0, 16'h0, 16'h0, 1, 4'b0011, 4'd4);
        step("both4", 1, 4'b0011, 4'd4, 16'h4444, 16'h0, 1, 4'b0011, 4'd4);
        check_eq("both4.busy4", 32'(busy[4]), 32'd1);
        step("ret4",  1, 4'b0011, 4'd4, 16'h4445, 16'h0, 0, 4'h0, 4'd0);
        check_eq("ret4.busy4", 32'(busy[4]), 32'd0);

        // r0 never writes nor goes busy; decrement at 0 does not wrap
        step("dst0a", 1, 4'b0001, 4'd0, 16'hDEAD, 16'h0, 1, 4'b0001, 4'd0);
        check_eq("dst0a.busy0", 32'(busy[0]), 32'd0);
        step("dst0b", 1, 4'b1011, 4'd0, 16'h0, 16'hCAFE, 1, 4'b1011, 4'd0);
        step("dec0",  1, 4'b0001, 4'd10, 16'h0A0A, 16'h0, 0, 4'h0, 4'd0);
        check_eq("dec0.busy10", 32'(busy[10]), 32'd0);
        step("nostl", 0, 4'h0, 4'd0, 16'h0, 16'h0, 1, 4'b0001, 4'd10);

        // back-to-back strobes with cross-register issue/retire and random data
        for (int i = 0; i < 8; i++) begin
            step("b2b", 1, 4'($urandom_range(0, 11)), 4'($urandom_range(1, 15)),
                 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        // reset with pending writes on r2 and r9
        step("iss2",  0, 4'h0, 4'd0, 16'h0, 16'h0, 1, 4'b0001, 4'd2);
        step("iss9",  0, 4'h0, 4'd0, 16'h0, 16'h0, 1, 4'b0001, 4'd9);
        check_eq("pre_rst.busy", 32'(busy & 16'h0204), 32'h0204);
        do_reset("rst1");
        check_eq("rst1.lit_busy", 32'(busy), 32'h0);

        // retire counter wrap: 65535 nops, then one more
        in_valid = 1'b1; in_opcode = 4'b1111; in_dest = 4'd0; issue_valid = 1'b0;
        repeat (65535) @(posedge clock);
        #1;
        m_cnt = 16'hFFFF; m_we = 1'b0;
        check_eq("wrap.pre", 32'(retire_count), 32'hFFFF);
        step("wrap", 1, 4'b1111, 4'd0, 16'h0, 16'h0, 0, 4'h0, 4'd0);
        check_eq("wrap.lit", 32'(retire_count), 32'h0000);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
